// File: rtl/ethernet_pkg.sv
// rtl/ethernet_pkg.sv - shared Ethernet datapath types and RMII dibit/byte defaults
package ethernet_pkg;

  localparam int RMII_LANE_W      = 2;
  localparam int RMII_GROUP_LANES = 4;

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    SEND_A = 2'd2,
    SEND_B = 2'd3
  } reorder_state_t;

endpackage

// File: rtl/lane_reorder_if.sv
// rtl/lane_reorder_if.sv - lane stream in/out bundle for lane_reorder
interface lane_reorder_if
  import ethernet_pkg::*;
#(
  parameter int LANE_W = RMII_LANE_W
);

  logic              reverse;
  logic              axiiv;
  logic [LANE_W-1:0] axiid;
  logic              axiov;
  logic [LANE_W-1:0] axiod;
  logic              partial;

  modport master (
    output reverse, axiiv, axiid,
    input  axiov, axiod, partial
  );

  modport slave (
    input  reverse, axiiv, axiid,
    output axiov, axiod, partial
  );

endinterface

// File: rtl/reorder_group_buf.sv
// rtl/reorder_group_buf.sv - one group of lane storage plus the reverse mode latched with slot 0
module reorder_group_buf
  import ethernet_pkg::*;
#(
  parameter int LANE_W      = RMII_LANE_W,
  parameter int GROUP_LANES = RMII_GROUP_LANES,
  localparam int IDX_W      = $clog2(GROUP_LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [LANE_W-1:0] wr_data,
  input  logic              wr_rev,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [LANE_W-1:0] rd_data,
  output logic              rev
);

  logic [LANE_W-1:0] mem [GROUP_LANES];

  // The mode belongs to the group, so it is captured only with the first lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GROUP_LANES; i++) mem[i] <= '0;
      rev <= 1'b0;
    end else if (we) begin
      mem[wr_idx] <= wr_data;
      if (wr_idx == '0) rev <= wr_rev;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/lane_reorder.sv
// rtl/lane_reorder.sv - ping-pong lane-order converter: collects a group of lanes, re-emits it reversed or in order
module lane_reorder
  import ethernet_pkg::*;
#(
  parameter int LANE_W      = RMII_LANE_W,
  parameter int GROUP_LANES = RMII_GROUP_LANES
) (
  input  logic          clk,
  input  logic          rst_n,
  lane_reorder_if.slave bus
);

  localparam int               IDX_W = $clog2(GROUP_LANES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(GROUP_LANES - 1);

  reorder_state_t    state, state_nxt;
  logic [IDX_W-1:0]  fill_cnt, send_cnt, rd_idx;
  logic              fill_into_a, sending, send_from_a;
  logic              complete, last_send, send_rev;
  logic              rev_a, rev_b;
  logic [LANE_W-1:0] rd_a, rd_b;
  logic [LANE_W-1:0] axiod_c;
  logic              axiov_c;
  logic              partial_q;

  assign fill_into_a = (state == FILL_A) || (state == SEND_B);
  assign sending     = (state == SEND_A) || (state == SEND_B);
  assign send_from_a = (state == SEND_A);
  assign complete    = bus.axiiv && (fill_cnt == LAST);
  assign last_send   = (send_cnt == LAST);
  assign send_rev    = send_from_a ? rev_a : rev_b;
  assign rd_idx      = send_rev ? (LAST - send_cnt) : send_cnt;

  reorder_group_buf #(
    .LANE_W      (LANE_W),
    .GROUP_LANES (GROUP_LANES)
  ) u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.axiiv && fill_into_a),
    .wr_idx  (fill_cnt),
    .wr_data (bus.axiid),
    .wr_rev  (bus.reverse),
    .rd_idx  (rd_idx),
    .rd_data (rd_a),
    .rev     (rev_a)
  );

  reorder_group_buf #(
    .LANE_W      (LANE_W),
    .GROUP_LANES (GROUP_LANES)
  ) u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.axiiv && !fill_into_a),
    .wr_idx  (fill_cnt),
    .wr_data (bus.axiid),
    .wr_rev  (bus.reverse),
    .rd_idx  (rd_idx),
    .rd_data (rd_b),
    .rev     (rev_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL_A;
    else        state <= state_nxt;
  end

  // A group completing on the last send edge hands over with no idle cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL_A:  if (complete) state_nxt = SEND_A;
      FILL_B:  if (complete) state_nxt = SEND_B;
      SEND_A:  if (last_send) state_nxt = complete ? SEND_B : FILL_B;
      SEND_B:  if (last_send) state_nxt = complete ? SEND_A : FILL_A;
      default: state_nxt = FILL_A;
    endcase
  end

  always_comb begin
    axiov_c = sending;
    axiod_c = '0;
    if (sending) axiod_c = send_from_a ? rd_a : rd_b;
  end

  assign bus.axiov   = axiov_c;
  assign bus.axiod   = axiod_c;
  assign bus.partial = partial_q;

  // A gap in the middle of a group drops what was captured so far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt  <= '0;
      partial_q <= 1'b0;
    end else begin
      partial_q <= !bus.axiiv && (fill_cnt != '0);
      if (bus.axiiv) fill_cnt <= complete ? '0 : fill_cnt + 1'b1;
      else           fill_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       send_cnt <= '0;
    else if (sending) send_cnt <= last_send ? '0 : send_cnt + 1'b1;
    else              send_cnt <= '0;
  end

  // The filling buffer must never complete while the other is still mid-send.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(sending && complete && !last_send));

endmodule
